// File: rtl/uart_loader.sv
// Boot loader: receives a length-prefixed program image over UART, writes it into
// instruction memory, sends one acknowledge byte, then releases the CPU.
module uart_loader #(
  parameter int          ADDR_W   = 15,
  parameter logic [7:0]  ACK_BYTE = 8'hAA
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              tx_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              loaded,
  output logic              err
);

  typedef enum logic [2:0] {S_LEN, S_LOAD, S_ACK, S_RUN, S_ERR} state_t;

  // One bit wider than a word so that a length of exactly 2^ADDR_W is representable.
  localparam logic [32:0] CAPACITY = 33'd1 << ADDR_W;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_byte_cnt;
  logic [31:0]       r_shift;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_word_cnt;
  logic              w_take;
  logic              w_word_done;
  logic [31:0]       w_word;
  logic [ADDR_W:0]   w_cnt_inc;

  assign tx_data   = ACK_BYTE;
  assign w_word    = {rx_data, r_shift[31:8]};
  assign w_cnt_inc = r_word_cnt + (ADDR_W+1)'(1);

  // NOTE: every signal driven here gets a value before the case so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_take      = rx_valid && (r_state == S_LEN || r_state == S_LOAD);
    w_word_done = w_take && (r_byte_cnt == 2'd3);
    case (r_state)
      S_LEN: begin
        if (w_word_done) begin
          if (w_word == 32'd0)                w_state_nxt = S_ACK;
          else if ({1'b0, w_word} > CAPACITY) w_state_nxt = S_ERR;
          else                                w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_word_done && (w_cnt_inc == r_len)) w_state_nxt = S_ACK;
      end
      S_ACK: begin
        if (tx_valid && tx_ready) w_state_nxt = S_RUN;
      end
      default: ;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_LEN;
      r_byte_cnt <= 2'd0;
      r_shift    <= 32'd0;
      r_len      <= '0;
      r_word_cnt <= '0;
      tx_valid   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      cpu_rst    <= 1'b1;
      loaded     <= 1'b0;
      err        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_take) begin
        r_shift    <= w_word;
        r_byte_cnt <= r_byte_cnt + 2'd1;
      end
      if (w_word_done && r_state == S_LEN) begin
        r_len      <= w_word[ADDR_W:0];
        r_word_cnt <= '0;
      end
      imem_we <= w_word_done && (r_state == S_LOAD);
      if (w_word_done && r_state == S_LOAD) begin
        imem_addr  <= r_word_cnt[ADDR_W-1:0];
        imem_wdata <= w_word;
        r_word_cnt <= w_cnt_inc;
      end
      // Status outputs are registered copies of the state being entered.
      tx_valid <= (w_state_nxt == S_ACK);
      cpu_rst  <= (w_state_nxt != S_RUN);
      loaded   <= (w_state_nxt == S_RUN);
      err      <= (w_state_nxt == S_ERR);
    end
  end

endmodule
